snake_core: RTL and testbench
=============================

SNAKE_CORE -- requirements
Module: snake_core

Interface
REQ-001 SHALL have parameter GRID_W, default 32, grid columns.
REQ-002 SHALL have parameter GRID_H, default 24, grid rows.
REQ-003 SHALL have parameter MAX_LEN, default 64, maximum segments; power of two.
REQ-004 SHALL have derived parameter ADDR_W, default clog2(GRID_W*GRID_H), cell address width.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port tick, input, 1, one-cycle pulse requesting one game step.
REQ-008 SHALL have port direction, input, 2, encoding LEFT=0, TOP=1, RIGHT=2, DOWN=3.
REQ-009 SHALL have port apple_pos, input, ADDR_W, current apple cell.
REQ-010 SHALL have port rd_idx, input, clog2(MAX_LEN), body read index; 0 = head.
REQ-011 SHALL have outputs: head_pos (ADDR_W), tail_pos (ADDR_W), length (clog2(MAX_LEN)+1), rd_pos (ADDR_W), busy (1), apple_eaten (1), game_over (1).

Function
REQ-012 SHALL implement FSM IDLE -> SCAN -> COMMIT -> IDLE, plus terminal OVER.
REQ-013 IDLE: tick=1 and game_over=0 -> latch next head, go to SCAN; busy=0 only in IDLE.
REQ-014 A tick outside IDLE or in OVER SHALL be ignored: no queueing, no state change.
REQ-015 Direction latched at tick acceptance; a request exactly opposite the current heading (dir XOR 2) SHALL be ignored and the heading kept.
REQ-016 Next head: LEFT -1, RIGHT +1, TOP -GRID_W, DOWN +GRID_W; row/column boundary handling per REQ-027.
REQ-017 grow = (next head == apple_pos); evaluated at acceptance.
REQ-018 SCAN SHALL compare the next head against one stored segment per cycle, L cycles for L = length; the current tail segment is excluded when grow=0.
REQ-019 Match in SCAN -> OVER; game_over=1 next cycle; body unchanged.
REQ-020 COMMIT: push next head into ring buffer; advance the tail pointer unless grow=1 and length<MAX_LEN.
REQ-021 At length==MAX_LEN, eating SHALL still pulse apple_eaten, but length saturates and the tail advances.
REQ-022 Tick accepted in cycle t -> head_pos, tail_pos and length updated at t+L+2; apple_eaten high for exactly that one cycle.
REQ-023 rd_pos SHALL be registered: rd_pos = segment rd_idx, one cycle after rd_idx; 0 if rd_idx >= length.
REQ-024 Arithmetic in ADDR_W bits; row/column derived by division/modulo on constant GRID_W only.

Reset
REQ-025 reset SHALL override all inputs, including mid-SCAN.
REQ-026 Reset values: state IDLE; head_pos = tail_pos = (GRID_H/2)*GRID_W + GRID_W/2; length 1; heading RIGHT; busy 0; apple_eaten 0; game_over 0; rd_pos 0; ring pointers 0.

Configuration
REQ-027 Macro SNAKE_WRAP_EN defined: moving off an edge wraps to the opposite edge, same row/column. Undefined: leaving the grid -> OVER after the acceptance cycle, no SCAN.

Structure
REQ-028 Shared package snake_pkg SHALL hold direction encodings, default GRID_W/GRID_H/MAX_LEN and the mid-cell function.
REQ-029 Ring buffer SHALL be sub-module snake_body_ring (MAX_LEN x ADDR_W, head/tail pointers, scan read port, rd port).

Verification (defaults, wrap enabled unless stated)
REQ-030 Reset, apple_pos=0, tick with RIGHT -> head_pos 401 at t+3, length 1, apple_eaten 0.
REQ-031 Head 400, apple_pos 401, tick RIGHT -> length 2, head 401, tail 400, apple_eaten single pulse.
REQ-032 Head 16, tick TOP -> head 752; head 384, tick LEFT -> head 415; SNAKE_WRAP_EN undefined, same LEFT -> game_over 1, head stays 384.
REQ-033 Length 2 heading RIGHT, tick LEFT -> moves RIGHT (head+1); tick during busy -> ignored, one step only.
REQ-034 Length 5 snake, steps DOWN, LEFT, TOP, RIGHT into its own body -> game_over 1 after L+1 cycles; further ticks ignored until reset.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game core.
// Direction codes, grid defaults and the start-cell helper.
package snake_pkg;

    localparam int DEF_GRID_W  = 32;
    localparam int DEF_GRID_H  = 24;
    localparam int DEF_MAX_LEN = 64;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_TOP   = 2'd1,
        DIR_RIGHT = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_COMMIT,
        ST_OVER
    } state_t;

    // Cell in the middle of the grid, where the snake starts.
    function automatic int mid_cell(input int w, input int h);
        return (h / 2) * w + w / 2;
    endfunction

endpackage

// File: rtl/snake_body_ring.sv
// Ring buffer of snake body cells, segment 0 is the head.
// Async scan/tail read ports, registered rd port.
module snake_body_ring
    import snake_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int ADDR_W  = 10,
    parameter logic [ADDR_W-1:0] RST_POS = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_adv,
    input  logic [ADDR_W-1:0]          i_data,
    input  logic [$clog2(MAX_LEN)-1:0] i_scan_idx,
    input  logic [$clog2(MAX_LEN)-1:0] i_rd_idx,
    input  logic [$clog2(MAX_LEN):0]   i_length,
    output logic [ADDR_W-1:0]          o_scan_pos,
    output logic [ADDR_W-1:0]          o_tail_pos,
    output logic [ADDR_W-1:0]          o_rd_pos
);

    localparam int IDX_W = $clog2(MAX_LEN);
    localparam logic [IDX_W-1:0] C_IDX_ONE = IDX_W'(1);

    logic [ADDR_W-1:0] r_mem [MAX_LEN];
    logic [IDX_W-1:0]  r_head_ptr;
    logic [IDX_W-1:0]  r_tail_ptr;
    logic [ADDR_W-1:0] r_rd_pos;
    logic [IDX_W-1:0]  w_scan_addr;
    logic [IDX_W-1:0]  w_rd_addr;
    logic [IDX_W-1:0]  w_push_addr;

    // Segment i lives i slots behind the head pointer.
    assign w_scan_addr = r_head_ptr - i_scan_idx;
    assign w_rd_addr   = r_head_ptr - i_rd_idx;
    assign w_push_addr = r_head_ptr + C_IDX_ONE;

    assign o_scan_pos = r_mem[w_scan_addr];
    assign o_tail_pos = r_mem[r_tail_ptr];
    assign o_rd_pos   = r_rd_pos;

    // Head/tail pointers: head always steps on push, tail only when told.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head_ptr <= '0;
            r_tail_ptr <= '0;
        end else if (i_push) begin
            r_head_ptr <= w_push_addr;
            if (i_adv) begin
                r_tail_ptr <= r_tail_ptr + C_IDX_ONE;
            end
        end
    end

    // Body storage: reset seeds the single starting segment.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem[0] <= RST_POS;
        end else if (i_push) begin
            r_mem[w_push_addr] <= i_data;
        end
    end

    // Debug/render read port, zero outside the live body.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_pos <= '0;
        end else if ({1'b0, i_rd_idx} < i_length) begin
            r_rd_pos <= r_mem[w_rd_addr];
        end else begin
            r_rd_pos <= '0;
        end
    end

endmodule

// File: rtl/snake_core.sv
// Snake game step engine: IDLE -> SCAN -> COMMIT, terminal OVER.
// SNAKE_WRAP_EN: defined = edges wrap, undefined = leaving grid ends game.
module snake_core
    import snake_pkg::*;
#(
    parameter int GRID_W  = DEF_GRID_W,
    parameter int GRID_H  = DEF_GRID_H,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int ADDR_W  = $clog2(GRID_W * GRID_H)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick,
    input  logic [1:0]                 direction,
    input  logic [ADDR_W-1:0]          apple_pos,
    input  logic [$clog2(MAX_LEN)-1:0] rd_idx,
    output logic [ADDR_W-1:0]          head_pos,
    output logic [ADDR_W-1:0]          tail_pos,
    output logic [$clog2(MAX_LEN):0]   length,
    output logic [ADDR_W-1:0]          rd_pos,
    output logic                       busy,
    output logic                       apple_eaten,
    output logic                       game_over
);

    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int LEN_W = IDX_W + 1;

    localparam logic [ADDR_W-1:0] C_MID      = ADDR_W'(mid_cell(GRID_W, GRID_H));
    localparam logic [ADDR_W-1:0] C_ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] C_W        = ADDR_W'(GRID_W);
    localparam logic [ADDR_W-1:0] C_COL_LAST = ADDR_W'(GRID_W - 1);
    localparam logic [ADDR_W-1:0] C_ROW_LAST = ADDR_W'(GRID_H - 1);
    localparam logic [ADDR_W-1:0] C_VSPAN    = ADDR_W'((GRID_H - 1) * GRID_W);
    localparam logic [LEN_W-1:0]  C_MAXLEN   = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]  C_LEN_ONE  = LEN_W'(1);
    localparam logic [IDX_W-1:0]  C_IDX_ONE  = IDX_W'(1);

    state_t            r_state;
    state_t            w_state_nx;
    dir_t              r_heading;
    dir_t              w_dir;
    logic [ADDR_W-1:0] r_head_pos;
    logic [ADDR_W-1:0] r_next;
    logic              r_grow;
    logic [LEN_W-1:0]  r_length;
    logic [IDX_W-1:0]  r_scan_idx;
    logic              r_apple_eaten;

    logic [ADDR_W-1:0] w_next;
    logic              w_oob;
    logic              w_grow;
    logic [ADDR_W-1:0] w_col;
    logic [ADDR_W-1:0] w_row;
    logic              w_accept;
    logic              w_last;
    logic              w_hit;
    logic              w_push;
    logic              w_adv;
    logic [ADDR_W-1:0] w_scan_pos;

    // Reversal requests are dropped: keep the current heading.
    assign w_dir = (dir_t'(direction ^ 2'b10) == r_heading) ?
                   r_heading : dir_t'(direction);

    assign w_col    = r_head_pos % C_W;
    assign w_row    = r_head_pos / C_W;
    assign w_grow   = (w_next == apple_pos);
    assign w_accept = tick && (r_state == ST_IDLE);

    // The tail cell is vacated on a non-growing step, so skip it then.
    assign w_last = ({1'b0, r_scan_idx} == (r_length - C_LEN_ONE));
    assign w_hit  = (r_state == ST_SCAN) && (r_grow || !w_last) &&
                    (w_scan_pos == r_next);

    assign w_push = (r_state == ST_COMMIT);
    assign w_adv  = !(r_grow && (r_length < C_MAXLEN));

    assign head_pos    = r_head_pos;
    assign length      = r_length;
    assign busy        = (r_state != ST_IDLE);
    assign apple_eaten = r_apple_eaten;
    assign game_over   = (r_state == ST_OVER);

    // Next head cell from the effective direction, with edge handling.
    always_comb begin
        w_next = r_head_pos;
        w_oob  = 1'b0;
        unique case (w_dir)
            DIR_LEFT: begin
                if (w_col == '0) begin
`ifdef SNAKE_WRAP_EN
                    w_next = r_head_pos + C_COL_LAST;
`else
                    w_oob = 1'b1;
`endif
                end else begin
                    w_next = r_head_pos - C_ONE;
                end
            end
            DIR_RIGHT: begin
                if (w_col == C_COL_LAST) begin
`ifdef SNAKE_WRAP_EN
                    w_next = r_head_pos - C_COL_LAST;
`else
                    w_oob = 1'b1;
`endif
                end else begin
                    w_next = r_head_pos + C_ONE;
                end
            end
            DIR_TOP: begin
                if (w_row == '0) begin
`ifdef SNAKE_WRAP_EN
                    w_next = r_head_pos + C_VSPAN;
`else
                    w_oob = 1'b1;
`endif
                end else begin
                    w_next = r_head_pos - C_W;
                end
            end
            DIR_DOWN: begin
                if (w_row == C_ROW_LAST) begin
`ifdef SNAKE_WRAP_EN
                    w_next = r_head_pos - C_VSPAN;
`else
                    w_oob = 1'b1;
`endif
                end else begin
                    w_next = r_head_pos + C_W;
                end
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (tick) begin
                    w_state_nx = w_oob ? ST_OVER : ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_hit) begin
                    w_state_nx = ST_OVER;
                end else if (w_last) begin
                    w_state_nx = ST_COMMIT;
                end
            end
            ST_COMMIT: w_state_nx = ST_IDLE;
            ST_OVER:   w_state_nx = ST_OVER;
        endcase
    end

    // Step datapath: latch request, walk the body, then commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_heading     <= DIR_RIGHT;
            r_head_pos    <= C_MID;
            r_next        <= '0;
            r_grow        <= 1'b0;
            r_length      <= C_LEN_ONE;
            r_scan_idx    <= '0;
            r_apple_eaten <= 1'b0;
        end else begin
            r_apple_eaten <= 1'b0;
            if (w_accept) begin
                r_heading  <= w_dir;
                r_next     <= w_next;
                r_grow     <= w_grow;
                r_scan_idx <= '0;
            end else if (r_state == ST_SCAN) begin
                r_scan_idx <= r_scan_idx + C_IDX_ONE;
            end
            if (r_state == ST_COMMIT) begin
                r_head_pos    <= r_next;
                r_apple_eaten <= r_grow;
                if (r_grow && (r_length < C_MAXLEN)) begin
                    r_length <= r_length + C_LEN_ONE;
                end
            end
        end
    end

    snake_body_ring #(
        .MAX_LEN (MAX_LEN),
        .ADDR_W  (ADDR_W),
        .RST_POS (C_MID)
    ) u_ring (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_adv      (w_adv),
        .i_data     (r_next),
        .i_scan_idx (r_scan_idx),
        .i_rd_idx   (rd_idx),
        .i_length   (r_length),
        .o_scan_pos (w_scan_pos),
        .o_tail_pos (tail_pos),
        .o_rd_pos   (rd_pos)
    );

endmodule

// File: tb/tb_snake_core.sv
// Self-checking bench for snake_core.
// Step vectors go through a scoreboard queue; corner cases are hand-driven.
module tb_snake_core;

    localparam int GW = 32;
    localparam int GH = 24;
    localparam int ML = 64;
    localparam int AW = 10;
    localparam int IW = 6;

    localparam int DL = 0;
    localparam int DT = 1;
    localparam int DR = 2;
    localparam int DD = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b0;
    logic [1:0]    direction = 2'd2;
    logic [AW-1:0] apple_pos = '0;
    logic [IW-1:0] rd_idx = '0;
    logic [AW-1:0] head_pos;
    logic [AW-1:0] tail_pos;
    logic [IW:0]   length;
    logic [AW-1:0] rd_pos;
    logic          busy;
    logic          apple_eaten;
    logic          game_over;

    snake_core #(
        .GRID_W  (GW),
        .GRID_H  (GH),
        .MAX_LEN (ML)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .direction   (direction),
        .apple_pos   (apple_pos),
        .rd_idx      (rd_idx),
        .head_pos    (head_pos),
        .tail_pos    (tail_pos),
        .length      (length),
        .rd_pos      (rd_pos),
        .busy        (busy),
        .apple_eaten (apple_eaten),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst;
        int dir;
        int apple;
        int head;
        int tail;
        int len;
        int eat;
        int over;
    } vec_t;

    vec_t tab[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   prev_len = 1;

    function automatic vec_t mk(bit rst, int dir, int apple, int head,
                                int tail, int len, int eat, int over);
        vec_t v;
        v.rst = rst; v.dir = dir; v.apple = apple; v.head = head;
        v.tail = tail; v.len = len; v.eat = eat; v.over = over;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        tick  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        prev_len = 1;
        chk("rst_head", int'(head_pos), 400);
        chk("rst_tail", int'(tail_pos), 400);
        chk("rst_len", int'(length), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_over", int'(game_over), 0);
        chk("rst_eat", int'(apple_eaten), 0);
    endtask

    task automatic run_vec(input vec_t v);
        int   cyc;
        int   eat;
        vec_t e;
        cyc = 0;
        eat = 0;
        sb.push_back(v);
        direction = 2'(v.dir);
        apple_pos = AW'(v.apple);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        while (busy && !game_over && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (apple_eaten) eat++;
        end
        chk("step_in_time", int'(cyc < 200), 1);
        @(negedge clk);
        if (apple_eaten) eat++;
        e = sb.pop_front();
        chk("head", int'(head_pos), e.head);
        chk("tail", int'(tail_pos), e.tail);
        chk("len", int'(length), e.len);
        chk("over", int'(game_over), e.over);
        chk("eat_pulses", eat, e.eat);
        if (e.over == 0) begin
            chk("latency", cyc, prev_len + 1);
        end
        prev_len = e.len;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_in [7];
        int rd_exp [7];

        // single plain step
        tab.push_back(mk(1, DR, 0, 401, 401, 1, 0, 0));
        // eat, then reversal request ignored
        tab.push_back(mk(1, DR, 401, 401, 400, 2, 1, 0));
        tab.push_back(mk(0, DL, 0, 402, 401, 2, 0, 0));
        // climb to the top row, then cross it
        for (int k = 1; k <= 12; k++) begin
            tab.push_back(mk(k == 1, DT, 0, 400 - 32 * k, 400 - 32 * k,
                             1, 0, 0));
        end
`ifdef SNAKE_WRAP_EN
        tab.push_back(mk(0, DT, 0, 752, 752, 1, 0, 0));
`else
        tab.push_back(mk(0, DT, 0, 16, 16, 1, 0, 1));
`endif
        // walk to column 0 of row 12, then cross the left edge
        tab.push_back(mk(1, DD, 0, 432, 432, 1, 0, 0));
        for (int k = 1; k <= 16; k++) begin
            tab.push_back(mk(0, DL, 0, 432 - k, 432 - k, 1, 0, 0));
        end
        tab.push_back(mk(0, DT, 0, 384, 384, 1, 0, 0));
`ifdef SNAKE_WRAP_EN
        tab.push_back(mk(0, DL, 0, 415, 415, 1, 0, 0));
`else
        tab.push_back(mk(0, DL, 0, 384, 384, 1, 0, 1));
`endif
        // length 4 loop: head may enter the cell the tail leaves
        tab.push_back(mk(1, DT, 368, 368, 400, 2, 1, 0));
        tab.push_back(mk(0, DL, 367, 367, 400, 3, 1, 0));
        tab.push_back(mk(0, DD, 399, 399, 400, 4, 1, 0));
        tab.push_back(mk(0, DR, 0, 400, 368, 4, 0, 0));
        tab.push_back(mk(0, DT, 0, 368, 367, 4, 0, 0));
        // length 5, then DOWN LEFT TOP RIGHT into own body
        tab.push_back(mk(1, DT, 368, 368, 400, 2, 1, 0));
        tab.push_back(mk(0, DL, 367, 367, 400, 3, 1, 0));
        tab.push_back(mk(0, DL, 366, 366, 400, 4, 1, 0));
        tab.push_back(mk(0, DL, 365, 365, 400, 5, 1, 0));
        tab.push_back(mk(0, DD, 0, 397, 368, 5, 0, 0));
        tab.push_back(mk(0, DL, 0, 396, 367, 5, 0, 0));
        tab.push_back(mk(0, DT, 0, 364, 366, 5, 0, 0));
        tab.push_back(mk(0, DR, 0, 364, 366, 5, 0, 1));

        for (int i = 0; i < tab.size(); i++) begin
            if (tab[i].rst) do_reset();
            run_vec(tab[i]);
        end

        // ticks in OVER change nothing
        direction = 2'(DD);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (8) @(negedge clk);
        chk("over_hold", int'(game_over), 1);
        chk("over_head", int'(head_pos), 364);
        chk("over_len", int'(length), 5);
        chk("over_busy", int'(busy), 1);

        // body left intact after the crash
        rd_in  = '{0, 1, 2, 3, 4, 5, 63};
        rd_exp = '{364, 396, 397, 365, 366, 0, 0};
        for (int i = 0; i < 7; i++) begin
            rd_idx = IW'(rd_in[i]);
            @(negedge clk);
            chk($sformatf("rd_pos[%0d]", rd_in[i]), int'(rd_pos), rd_exp[i]);
        end

        // tick held through SCAN and COMMIT: only one step
        do_reset();
        direction = 2'(DR);
        apple_pos = '0;
        tick = 1'b1;
        repeat (3) @(negedge clk);
        tick = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_tick_head", int'(head_pos), 401);
        chk("busy_tick_busy", int'(busy), 0);
        chk("busy_tick_len", int'(length), 1);

        // reset during SCAN wins over a pending step and a tick
        do_reset();
        direction = 2'(DT);
        tick = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_head", int'(head_pos), 400);
        repeat (3) @(negedge clk);
        chk("midrst_head_late", int'(head_pos), 400);
        chk("midrst_over", int'(game_over), 0);
        // heading back to RIGHT, so LEFT is a reversal
        prev_len = 1;
        run_vec(mk(0, DL, 0, 401, 401, 1, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
